reg_bank_writer: RTL and testbench
==================================

// Module: reg_bank_writer
// PURPOSE
//  Write side of the 8-entry x 17-bit register bank; the companion of the 8:1 selection mux that reads it.
//  Accepts write requests (3-bit Selection + 17-bit data) over a valid/ready handshake into a 2-entry FIFO.
//  Retires at most one FIFO entry per cycle by decoding Selection to a one-hot enable.
//  Sits at the datapath writeback stage; Stall holds retirement while the CPU is halted.
// PARAMETERS
//  WIDTH   17  data width of each register and of WriteData
//  SELW    3   selection width; register count = 2**SELW (8)
//  DEPTH   2   FIFO entries (fixed at 2; count is 2 bits)
// PORTS
//  Clock           in   1      single clock, all state on rising edge
//  Reset           in   1      synchronous, active-high
//  WriteValid      in   1      write request present
//  WriteReady      out  1      FIFO can accept (count < DEPTH)
//  WriteSelection  in   SELW   destination register index
//  WriteData       in   WIDTH  value to store
//  Stall           in   1      1 = hold retirement, FIFO keeps accepting until full
//  ReadSel1        in   SELW   read port 1 index
//  ReadSel2        in   SELW   read port 2 index
//  ReadData1       out  WIDTH  committed contents of reg[ReadSel1], combinational
//  ReadData2       out  WIDTH  committed contents of reg[ReadSel2], combinational
//  Busy            out  1      FIFO non-empty (count != 0)
// BEHAVIOUR
//  - Reset (sampled at the edge): FIFO count=0, head/tail pointers=0, all 8 registers=0.
//    After reset: WriteReady=1, Busy=0, ReadData1/2=0. Reset mid-operation discards queued writes.
//  - Accept: WriteValid & WriteReady at an edge pushes {WriteSelection, WriteData} at tail.
//  - WriteReady = (count < 2), from registered count only; no combinational path from WriteValid/Stall.
//  - Retire: count != 0 & !Stall at an edge pops head and writes reg[head.sel] = head.data.
//  - Latency: a write accepted at edge N into an empty FIFO is visible on ReadData at edge N+1
//    (unstalled). No bypass: queued data is never forwarded to the read ports.
//  - Simultaneous accept + retire: count unchanged, both pointers advance, order preserved.
//  - Full (count=2): WriteReady=0 even if a retire occurs in the same cycle; the request is held.
//  - Register 0 is hardwired zero: a retire to index 0 pops the entry, leaves reg0=0.
//  - Writes retire strictly in acceptance order; two writes to the same index: the later one wins.
//  - Pointers wrap modulo DEPTH (1-bit). count range 0..2, never exceeds DEPTH.
//  - Stall never blocks Reset; Stall while empty has no effect.
// STRUCTURE
//  - Shared package regbank_pkg: WIDTH, SELW, NUM_REGS=8, and the FIFO entry layout
//    {sel[SELW-1:0], data[WIDTH-1:0]} (entry width SELW+WIDTH = 20).
//  - One sub-module: write_fifo2 (2-entry sync FIFO with count, push/pop, full/empty flags).
//  - Top level: SELW-to-one-hot decoder, 8 x WIDTH register array, two 8:1 read muxes.
// TESTING
//  1 Reset then WriteSel=1, WriteData=5, one-cycle valid -> Busy=1 next cycle; ReadData1(sel 1)=5 one edge later.
//  2 WriteSel=0, WriteData=15 -> entry retires, Busy returns 0, ReadData(sel 0)=0.
//  3 Stall=1, push 5->r2, 15->r3, third 7->r4 -> WriteReady=0 after 2nd accept, third held;
//    Stall=0 -> r2=5, r3=15, then r4=7 on consecutive edges.
//  4 Back-to-back 0x1FFFF->r5 then 0x00001->r5, no stall -> r5 ends 0x00001, never shows stale order.
//  5 Queue two writes under Stall, assert Reset one cycle -> count=0, Busy=0, all ReadData=0,
//    WriteReady=1; queued writes never appear.
//  6 Continuous valid at count=1 with retire each cycle (r6,r7 alternating) -> count stays 1, one write/cycle.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared sizing and FIFO entry layout for the register bank write side.
package regbank_pkg;

  localparam int WIDTH    = 17;
  localparam int SELW     = 3;
  localparam int NUM_REGS = 2 ** SELW;
  localparam int DEPTH    = 2;

  typedef struct packed {
    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] data;
  } wr_entry_t;

  function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SELW-1:0] i_sel);
    logic [NUM_REGS-1:0] w_oh;
    w_oh        = '0;
    w_oh[i_sel] = 1'b1;
    return w_oh;
  endfunction

endpackage

// File: rtl/write_fifo2.sv
// Two-entry synchronous FIFO holding pending register writes in acceptance order.
module write_fifo2
  import regbank_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_push,
  input  wr_entry_t i_push_entry,
  input  logic      i_pop,
  output wr_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  wr_entry_t  r_mem [DEPTH];
  logic       r_head;
  logic       r_tail;
  logic [1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // Full is judged on the registered count alone, so a same-cycle pop never frees a slot.
  assign o_full    = (r_count == 2'(DEPTH));
  assign o_empty   = (r_count == 2'd0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_head];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_count  <= 2'd0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_tail] <= i_push_entry;
        r_tail        <= ~r_tail;
      end
      if (w_do_pop) begin
        r_head <= ~r_head;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/reg_bank_writer.sv
// Write side of the 8 x 17-bit register bank: queued writes retire in order into the
// register array, with two combinational read ports showing committed contents only.
module reg_bank_writer
  import regbank_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             WriteValid,
  output logic             WriteReady,
  input  logic [SELW-1:0]  WriteSelection,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             Stall,
  input  logic [SELW-1:0]  ReadSel1,
  input  logic [SELW-1:0]  ReadSel2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  output logic             Busy
);

  wr_entry_t           w_push_entry;
  wr_entry_t           w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_retire;
  logic [NUM_REGS-1:0] w_wr_en;

  logic [WIDTH-1:0] r_regs [NUM_REGS];

  assign w_push_entry = '{sel: WriteSelection, data: WriteData};
  assign WriteReady   = ~w_full;
  assign Busy         = ~w_empty;
  assign w_retire     = ~w_empty & ~Stall;

  write_fifo2 u_fifo (
    .i_clk        (Clock),
    .i_rst        (Reset),
    .i_push       (WriteValid),
    .i_push_entry (w_push_entry),
    .i_pop        (w_retire),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  // Register 0 reads as zero: its enable is forced off so retires to it just drain the queue.
  always_comb begin
    w_wr_en    = w_retire ? sel_onehot(w_head.sel) : '0;
    w_wr_en[0] = 1'b0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_en[i]) begin
          r_regs[i] <= w_head.data;
        end
      end
    end
  end

  assign ReadData1 = r_regs[ReadSel1];
  assign ReadData2 = r_regs[ReadSel2];

endmodule

// File: tb/tb_reg_bank_writer.sv
// Bench for reg_bank_writer: directed scenarios then random traffic against a queue/array model.
module tb_reg_bank_writer;
  import regbank_pkg::*;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             WriteValid;
  logic             WriteReady;
  logic [SELW-1:0]  WriteSelection;
  logic [WIDTH-1:0] WriteData;
  logic             Stall;
  logic [SELW-1:0]  ReadSel1;
  logic [SELW-1:0]  ReadSel2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic             Busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] m_regs [NUM_REGS];
  int               q_sel  [$];
  logic [WIDTH-1:0] q_data [$];
  logic [SELW-1:0]  rs1 = '0;
  logic [SELW-1:0]  rs2 = '0;

  always #5 Clock = ~Clock;

  reg_bank_writer dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .WriteValid     (WriteValid),
    .WriteReady     (WriteReady),
    .WriteSelection (WriteSelection),
    .WriteData      (WriteData),
    .Stall          (Stall),
    .ReadSel1       (ReadSel1),
    .ReadSel2       (ReadSel2),
    .ReadData1      (ReadData1),
    .ReadData2      (ReadData2),
    .Busy           (Busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_ready"}, 32'(WriteReady), 32'(q_sel.size() < DEPTH));
    chk({tag, "_busy"},  32'(Busy),       32'(q_sel.size() != 0));
    chk({tag, "_rd1"},   32'(ReadData1),  32'(m_regs[ReadSel1]));
    chk({tag, "_rd2"},   32'(ReadData2),  32'(m_regs[ReadSel2]));
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      ReadSel1 = SELW'(i);
      ReadSel2 = SELW'(NUM_REGS - 1 - i);
      #1;
      chk({tag, "_rd1"}, 32'(ReadData1), 32'(m_regs[i]));
      chk({tag, "_rd2"}, 32'(ReadData2), 32'(m_regs[NUM_REGS - 1 - i]));
    end
    ReadSel1 = rs1;
    ReadSel2 = rs2;
  endtask

  // One clock: drive inputs, predict accept/retire from the model, advance the model, compare.
  task automatic step(input string tag, input logic v, input int s, input int d, input logic st);
    logic             acc;
    logic             ret;
    int               hs;
    logic [WIDTH-1:0] hd;
    WriteValid     = v;
    WriteSelection = SELW'(s);
    WriteData      = WIDTH'(d);
    Stall          = st;
    ReadSel1       = rs1;
    ReadSel2       = rs2;
    acc = v && (q_sel.size() < DEPTH);
    ret = (q_sel.size() != 0) && !st;
    @(posedge Clock);
    #1;
    if (ret) begin
      hs = q_sel.pop_front();
      hd = q_data.pop_front();
      if (hs != 0) m_regs[hs] = hd;
    end
    if (acc) begin
      q_sel.push_back(s);
      q_data.push_back(WIDTH'(d));
    end
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag, input logic st);
    Reset      = 1'b1;
    WriteValid = 1'b0;
    Stall      = st;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    q_sel.delete();
    q_data.delete();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    check_outputs(tag);
  endtask

  initial begin
    Reset = 1'b1; WriteValid = 1'b0; WriteSelection = '0; WriteData = '0;
    Stall = 1'b0; ReadSel1 = '0; ReadSel2 = '0;

    do_reset("reset", 1'b0);
    chk("reset_ready_const", 32'(WriteReady), 32'd1);
    chk("reset_busy_const",  32'(Busy),       32'd0);
    check_all_regs("reset_regs");

    // 1: single write, visible one edge after acceptance
    rs1 = 3'd1; rs2 = 3'd0;
    step("t1_acc", 1'b1, 1, 5, 1'b0);
    chk("t1_busy_const", 32'(Busy), 32'd1);
    chk("t1_not_yet",    32'(ReadData1), 32'd0);
    step("t1_ret", 1'b0, 0, 0, 1'b0);
    chk("t1_rd1_const",  32'(ReadData1), 32'd5);

    // 2: write to register 0 drains but stays zero
    step("t2_acc", 1'b1, 0, 15, 1'b0);
    step("t2_ret", 1'b0, 0, 0, 1'b0);
    chk("t2_r0_const",   32'(ReadData2), 32'd0);
    chk("t2_busy_const", 32'(Busy), 32'd0);

    // 3: fill under stall, third request held, then drain in order
    rs1 = 3'd2; rs2 = 3'd3;
    step("t3_a", 1'b1, 2, 5, 1'b1);
    step("t3_b", 1'b1, 3, 15, 1'b1);
    chk("t3_full_const", 32'(WriteReady), 32'd0);
    step("t3_held", 1'b1, 4, 7, 1'b1);
    step("t3_r2", 1'b1, 4, 7, 1'b0);
    chk("t3_r2_const", 32'(ReadData1), 32'd5);
    step("t3_r3", 1'b1, 4, 7, 1'b0);
    chk("t3_r3_const", 32'(ReadData2), 32'd15);
    rs1 = 3'd4;
    step("t3_r4", 1'b0, 0, 0, 1'b0);
    chk("t3_r4_const", 32'(ReadData1), 32'd7);

    // 4: back-to-back writes to the same register, later one wins
    rs1 = 3'd5;
    step("t4_a", 1'b1, 5, 'h1FFFF, 1'b0);
    step("t4_b", 1'b1, 5, 'h00001, 1'b0);
    chk("t4_mid_const", 32'(ReadData1), 32'h1FFFF);
    step("t4_c", 1'b0, 0, 0, 1'b0);
    chk("t4_end_const", 32'(ReadData1), 32'h00001);

    // 5: reset discards queued writes
    rs1 = 3'd6; rs2 = 3'd7;
    step("t5_a", 1'b1, 6, 'h123, 1'b1);
    step("t5_b", 1'b1, 7, 'h456, 1'b1);
    do_reset("t5_rst", 1'b1);
    step("t5_after", 1'b0, 0, 0, 1'b0);
    check_all_regs("t5_regs");

    // 6: steady stream, one accept and one retire per cycle
    step("t6_fill", 1'b1, 6, 'h10, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step("t6_stream", 1'b1, (i % 2 == 0) ? 7 : 6, 'h20 + i, 1'b0);
      chk("t6_busy_const",  32'(Busy), 32'd1);
      chk("t6_ready_const", 32'(WriteReady), 32'd1);
    end
    step("t6_drain", 1'b0, 0, 0, 1'b0);
    check_all_regs("t6_regs");

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rs1 = SELW'($urandom_range(0, NUM_REGS - 1));
      rs2 = SELW'($urandom_range(0, NUM_REGS - 1));
      if ($urandom_range(0, 59) == 0)
        do_reset("rnd_rst", 1'($urandom_range(0, 1)));
      else
        step("rnd", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, NUM_REGS - 1)),
             int'($urandom_range(0, (1 << WIDTH) - 1)), 1'($urandom_range(0, 2) == 0));
    end
    step("final_drain_a", 1'b0, 0, 0, 1'b0);
    step("final_drain_b", 1'b0, 0, 0, 1'b0);
    check_all_regs("final_regs");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
